// File: rtl/branch_predict_unit.sv
// branch_predict_unit: execute-stage branch resolution plus direct-mapped BTB with 2-bit counters (optional BP_STATS_EN counters)
module branch_predict_unit #(
  parameter int PC_W = 9,
  parameter int ENTRIES = 16,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic            ex_branch,
  input  logic [1:0]      ex_jal_type,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic [31:0]     pc_imm,
  output logic [31:0]     pc_four,
  output logic            pc_sel,
  output logic [31:0]     br_pc,
  output logic            mispredict,
`ifdef BP_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic [31:0]     redirect_pc
);
  localparam int TAG_W = PC_W - IDX_W - 2;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];
  logic [IDX_W-1:0]   if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic [31:0]        pc32;
  logic               if_hit, ex_hit, upd;
  logic               unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign if_hit = valid[if_idx] && tag[if_idx] == if_tag;
  assign ex_hit = valid[ex_idx] && tag[ex_idx] == ex_tag;
  assign pred_taken  = if_hit & ctr[if_idx][1];
  assign pred_target = pred_taken ? target[if_idx] : 32'd0;
  assign pc32 = {{(32-PC_W){1'b0}}, ex_pc};
  // Only JALR takes its target from the ALU; JAL, reserved and branches are pc-relative.
  assign pc_imm = ex_jal_type == 2'b01 ? {ex_alu_result[31:1], 1'b0} : pc32 + ex_imm;
  assign pc_four = pc32 + 32'd4;
  assign pc_sel = (ex_branch & ex_alu_result[0]) | (ex_jal_type != 2'b00);
  assign br_pc = pc_sel ? pc_imm : 32'd0;
  assign redirect_pc = pc_sel ? pc_imm : pc_four;
  assign mispredict = ex_valid & ((pc_sel != ex_pred_taken) | (pc_sel & ex_pred_taken & (ex_pred_target != pc_imm)));
  assign upd = ex_valid & (ex_branch | (ex_jal_type != 2'b00));
  // Train the table from resolved control instructions; taken misses allocate, not-taken misses are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (pc_sel) begin
        valid[ex_idx]  <= 1'b1;
        tag[ex_idx]    <= ex_tag;
        target[ex_idx] <= pc_imm;
        ctr[ex_idx]    <= !ex_hit ? 2'b10 : ctr[ex_idx] == 2'b11 ? 2'b11 : ctr[ex_idx] + 2'd1;
      end else if (ex_hit) begin
        ctr[ex_idx] <= ctr[ex_idx] == 2'b00 ? 2'b00 : ctr[ex_idx] - 2'd1;
      end
    end
  end
`ifdef BP_STATS_EN
  // Saturating event counters for resolved control instructions and mispredicts.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd && stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
      if (mispredict && stat_mispredicts != 32'hFFFF_FFFF) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;
  logic        clk = 0;
  logic        reset;
  logic [8:0]  if_pc, ex_pc;
  logic        pred_taken, ex_valid, ex_branch, ex_pred_taken, pc_sel, mispredict;
  logic [31:0] pred_target, ex_imm, ex_alu_result, ex_pred_target, pc_imm, pc_four, br_pc, redirect_pc;
  logic [1:0]  ex_jal_type;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif
  int n_chk = 0;
  int n_fail = 0;
  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_branch(ex_branch), .ex_jal_type(ex_jal_type),
    .ex_alu_result(ex_alu_result), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_imm(pc_imm), .pc_four(pc_four), .pc_sel(pc_sel), .br_pc(br_pc), .mispredict(mispredict),
`ifdef BP_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic v, input logic [8:0] pc, input logic [31:0] imm, input logic br,
                    input logic [1:0] jt, input logic [31:0] alu, input logic pt, input logic [31:0] ptg);
    ex_valid = v; ex_pc = pc; ex_imm = imm; ex_branch = br; ex_jal_type = jt;
    ex_alu_result = alu; ex_pred_taken = pt; ex_pred_target = ptg;
    #1;
  endtask
  task automatic look(input string tag, input logic [8:0] pc, input logic t, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
    chk({tag, "_target"}, pred_target, tgt);
  endtask
  initial begin
    reset = 1; if_pc = 0;
    ex(0, 0, 0, 0, 2'b00, 0, 0, 0);
    tick; tick;
    reset = 0;
    look("rst", 9'h40, 0, 0);
    for (int i = 0; i < 16; i++) look("empty", 9'(i * 4), 0, 0);
`ifdef BP_STATS_EN
    chk("stat_br_rst0", stat_branches, 0);
`endif
    if_pc = 9'h40;
    ex(1, 9'h40, 32'h20, 1, 2'b00, 1, 0, 0);
    chk("t2_sel", {31'd0, pc_sel}, 1);
    chk("t2_imm", pc_imm, 32'h60);
    chk("t2_four", pc_four, 32'h44);
    chk("t2_brpc", br_pc, 32'h60);
    chk("t2_misp", {31'd0, mispredict}, 1);
    chk("t2_redir", redirect_pc, 32'h60);
    chk("t2_oldread", {31'd0, pred_taken}, 0);
    tick;
    ex(0, 9'h40, 32'h20, 1, 2'b00, 1, 0, 0);
    look("t2_alloc", 9'h40, 1, 32'h60);
    for (int i = 0; i < 3; i++) begin
      ex(1, 9'h40, 32'h20, 1, 2'b00, 1, 1, 32'h60);
      chk("t3_taken_misp", {31'd0, mispredict}, 0);
      tick;
      look("t3_sat_inc", 9'h40, 1, 32'h60);
    end
    ex(1, 9'h40, 32'h20, 1, 2'b00, 0, 1, 32'h60);
    chk("t3_nt_misp", {31'd0, mispredict}, 1);
    chk("t3_nt_redir", redirect_pc, 32'h44);
    chk("t3_nt_brpc", br_pc, 0);
    tick;
    look("t3_ctr10", 9'h40, 1, 32'h60);
    tick;
    look("t3_ctr01", 9'h40, 0, 0);
    ex(1, 9'h40, 32'h20, 1, 2'b00, 0, 0, 0);
    chk("t3_nt_ok", {31'd0, mispredict}, 0);
    tick; tick;
    ex(1, 9'h40, 32'h20, 1, 2'b00, 1, 0, 0);
    chk("t3_tk_misp", {31'd0, mispredict}, 1);
    tick;
    look("t3_sat_dec", 9'h40, 0, 0);
    tick;
    ex(0, 9'h40, 32'h20, 1, 2'b00, 1, 0, 0);
    look("t3_ctr10b", 9'h40, 1, 32'h60);
    ex(1, 9'h10, 32'h1234, 0, 2'b01, 32'h85, 1, 32'h80);
    chk("t4_jalr_imm", pc_imm, 32'h84);
    chk("t4_jalr_sel", {31'd0, pc_sel}, 1);
    chk("t4_jalr_misp", {31'd0, mispredict}, 1);
    tick;
    ex(0, 9'h10, 32'h1234, 0, 2'b01, 32'h85, 1, 32'h80);
    look("t4_jalr_pred", 9'h10, 1, 32'h84);
    ex(1, 9'h50, 32'h100, 0, 2'b10, 0, 1, 32'h150);
    chk("t4_jal_imm", pc_imm, 32'h150);
    chk("t4_jal_misp", {31'd0, mispredict}, 0);
    tick;
    ex(1, 9'h50, 32'h100, 0, 2'b10, 0, 1, 32'h154);
    chk("t4_tgt_misp", {31'd0, mispredict}, 1);
    ex(0, 9'h50, 32'h100, 0, 2'b10, 0, 1, 32'h150);
    look("t4_alias_miss", 9'h10, 0, 0);
    look("t4_alias_hit", 9'h50, 1, 32'h150);
    ex(0, 9'h50, 32'hFFFF_FFFC, 0, 2'b11, 32'h85, 0, 0);
    chk("t4_rsv_imm", pc_imm, 32'h4C);
    chk("t4_rsv_sel", {31'd0, pc_sel}, 1);
    ex(1, 9'h20, 32'h8, 1, 2'b00, 0, 0, 0);
    chk("t4_nt_misp", {31'd0, mispredict}, 0);
    chk("t4_nt_redir", redirect_pc, 32'h24);
    tick;
    ex(0, 9'h80, 32'h20, 1, 2'b00, 1, 0, 0);
    look("t4_no_alloc", 9'h20, 0, 0);
    chk("t5_inv_misp", {31'd0, mispredict}, 0);
    chk("t5_inv_sel", {31'd0, pc_sel}, 1);
    tick;
    look("t5_inv_noalloc", 9'h80, 0, 0);
    look("t5_kept", 9'h40, 1, 32'h60);
    ex(1, 9'h40, 32'h20, 1, 2'b00, 0, 1, 32'h60);
    chk("t5_same_old", {31'd0, pred_taken}, 1);
    chk("t5_same_misp", {31'd0, mispredict}, 1);
    tick;
    ex(0, 9'h40, 32'h20, 1, 2'b00, 0, 0, 0);
    look("t5_same_new", 9'h40, 0, 0);
    ex(1, 9'h40, 32'h20, 1, 2'b00, 1, 0, 0);
    tick;
    look("t6_trained", 9'h40, 1, 32'h60);
    reset = 1;
    tick; tick;
    reset = 0;
    ex(0, 9'h40, 32'h20, 1, 2'b00, 1, 0, 0);
    look("t6_rst_gone", 9'h40, 0, 0);
    look("t6_rst_alias", 9'h50, 0, 0);
`ifdef BP_STATS_EN
    chk("t6_stat_br", stat_branches, 0);
    chk("t6_stat_misp", stat_mispredicts, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
